// File: rtl/mega65_kbd_scanner_if.sv
// Signal bundle between the MEGA65 keyboard scanner and its surroundings:
// the three keyboard wires, the caps-lock request and the parallel matrix result.
interface mega65_kbd_scanner_if #(
   parameter int MATRIX_BITS = 72
);
   logic                   kb_io0;
   logic                   kb_io1;
   logic                   kb_io2;
   logic                   capslock_led;
   logic [MATRIX_BITS-1:0] matrix;
   logic                   frame_done;

   modport master (
      output kb_io0,
      output kb_io1,
      output matrix,
      output frame_done,
      input  kb_io2,
      input  capslock_led
   );

   modport slave (
      input  kb_io0,
      input  kb_io1,
      input  matrix,
      input  frame_done,
      output kb_io2,
      output capslock_led
   );
endinterface

// File: rtl/mega65_kbd_scanner.sv
// Serial front end for the MEGA65 smart keyboard: drives the keyboard clock and
// sync/LED line, shifts the key matrix in and publishes it after two matching frames.
module mega65_kbd_scanner #(
   parameter int CLK_DIV     = 14,
   parameter int FRAME_BITS  = 128,
   parameter int MATRIX_BITS = 72
) (
   input  logic                    clk28mhz,
   input  logic                    reset_n,
   mega65_kbd_scanner_if.master    kbd
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};

   typedef enum logic {
      SHIFT  = 1'b0,
      COMMIT = 1'b1
   } state_t;

   state_t                 state_r;
   state_t                 state_next_s;
   logic [DIV_W-1:0]       div_r;
   logic [DIV_W-1:0]       div_next_s;
   logic [BIT_W-1:0]       bit_r;
   logic [BIT_W-1:0]       bit_next_s;
   logic                   kb_io0_r;
   logic                   kb_io1_r;
   logic                   kb_io1_next_s;
   logic                   caps_r;
   logic                   caps_next_s;
   logic [1:0]             sync_r;
   logic [MATRIX_BITS-1:0] raw_r;
   logic [MATRIX_BITS-1:0] raw_next_s;
   logic [MATRIX_BITS-1:0] prev_raw_r;
   logic [MATRIX_BITS-1:0] prev_raw_next_s;
   logic [MATRIX_BITS-1:0] matrix_r;
   logic [MATRIX_BITS-1:0] matrix_next_s;
   logic                   frame_done_r;
   logic                   div_wrap_s;
   logic                   rise_s;
   logic                   fall_s;
   logic                   commit_s;

   // kb_io1 carries the sync marker in bit 0 and the LED request in bit 1
   function automatic logic led_line(input logic [BIT_W-1:0] idx, input logic caps);
      logic val;
      case (idx)
         BIT_ZERO: val = 1'b1;
         BIT_ONE:  val = caps;
         default:  val = 1'b0;
      endcase
      return val;
   endfunction

   // Frame state register
   always_ff @(posedge clk28mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= SHIFT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: a single COMMIT cycle follows the falling edge that ends the frame
   always_comb begin
      state_next_s = state_r;
      commit_s     = 1'b0;
      case (state_r)
         SHIFT: begin
            if (fall_s && (bit_r == BIT_LAST)) begin
               state_next_s = COMMIT;
            end else begin
               state_next_s = SHIFT;
            end
         end
         COMMIT: begin
            commit_s     = 1'b1;
            state_next_s = SHIFT;
         end
         default: begin
            state_next_s = SHIFT;
         end
      endcase
   end

   // Clock divider, bit counter, serial output line and matrix capture
   always_comb begin
      div_wrap_s = (div_r == DIV_LAST);
      rise_s     = div_wrap_s && !kb_io0_r;
      fall_s     = div_wrap_s && kb_io0_r;

      if (div_wrap_s) begin
         div_next_s = {DIV_W{1'b0}};
      end else begin
         div_next_s = div_r + DIV_ONE;
      end

      if (fall_s) begin
         if (bit_r == BIT_LAST) begin
            bit_next_s = BIT_ZERO;
         end else begin
            bit_next_s = bit_r + BIT_ONE;
         end
         caps_next_s = kbd.capslock_led;
      end else begin
         bit_next_s  = bit_r;
         caps_next_s = caps_r;
      end
      kb_io1_next_s = led_line(bit_next_s, caps_next_s);

      // Commit clears raw first so a coincident sample still lands on top of it
      if (commit_s) begin
         raw_next_s      = {MATRIX_BITS{1'b1}};
         prev_raw_next_s = raw_r;
      end else begin
         raw_next_s      = raw_r;
         prev_raw_next_s = prev_raw_r;
      end
      for (int i = 0; i < MATRIX_BITS; i++) begin
         if (rise_s && (bit_r == BIT_W'(i))) begin
            raw_next_s[i] = sync_r[1];
         end else begin
            raw_next_s[i] = raw_next_s[i];
         end
      end

      if (commit_s && (raw_r == prev_raw_r)) begin
         matrix_next_s = raw_r;
      end else begin
         matrix_next_s = matrix_r;
      end
   end

   // Datapath registers
   always_ff @(posedge clk28mhz or negedge reset_n) begin
      if (!reset_n) begin
         div_r        <= {DIV_W{1'b0}};
         bit_r        <= BIT_ZERO;
         kb_io0_r     <= 1'b0;
         kb_io1_r     <= 1'b0;
         caps_r       <= 1'b0;
         sync_r       <= 2'b11;
         raw_r        <= {MATRIX_BITS{1'b1}};
         prev_raw_r   <= {MATRIX_BITS{1'b1}};
         matrix_r     <= {MATRIX_BITS{1'b1}};
         frame_done_r <= 1'b0;
      end else begin
         div_r        <= div_next_s;
         bit_r        <= bit_next_s;
         kb_io0_r     <= kb_io0_r ^ div_wrap_s;
         kb_io1_r     <= kb_io1_next_s;
         caps_r       <= caps_next_s;
         sync_r       <= {sync_r[0], kbd.kb_io2};
         raw_r        <= raw_next_s;
         prev_raw_r   <= prev_raw_next_s;
         matrix_r     <= matrix_next_s;
         frame_done_r <= (state_next_s == COMMIT);
      end
   end

   assign kbd.kb_io0     = kb_io0_r;
   assign kbd.kb_io1     = kb_io1_r;
   assign kbd.matrix     = matrix_r;
   assign kbd.frame_done = frame_done_r;
endmodule

// File: doc/mega65_kbd_scanner.md
Name: mega65_kbd_scanner

Overview:
- Serial front end for the MEGA65 smart keyboard controller.
- Generates the keyboard clock on kb_io0 and sends sync plus the caps-lock LED on kb_io1.
- Shifts the key matrix in from kb_io2 and presents a debounced, parallel, active-low 9x8 matrix.
- Sits directly upstream of the ZX-Uno core keyboard logic, which consumes matrix and frame_done.

Parameters:
- CLK_DIV, 14: clk28mhz cycles per half period of kb_io0; default gives 1 MHz.
- FRAME_BITS, 128: keyboard clock periods per frame.
- MATRIX_BITS, 72: leading frame bits captured as keys (9 columns x 8 rows).

Ports:
- clk28mhz  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- kb_io0  output  1  keyboard clock
- kb_io1  output  1  serial data to the keyboard: sync, then LED
- kb_io2  input  1  serial matrix data from the keyboard; asynchronous; 0 = pressed
- capslock_led  input  1  caps-lock LED request
- matrix  output  MATRIX_BITS  debounced key state; bit n = frame bit n; active-low
- frame_done  output  1  one-cycle pulse at the end of every frame

Behaviour:
- Reset (asynchronous, active-low) forces:
  - kb_io0=0, kb_io1=0, matrix=all 1s, frame_done=0.
  - div counter=0, bit counter=0, raw and previous-raw shift registers=all 1s.
  - kb_io2 synchronizer=1s, state=SHIFT.
- Reset mid-frame abandons the partial frame; matrix keeps no stale data.
- kb_io2 is synchronized through two flops before any use.
- div counter runs 0..CLK_DIV-1. On the wrap cycle, kb_io0 toggles, giving a period of 2*CLK_DIV cycles.
- Rising edge (kb_io0 going 0->1):
  - Sample synchronized kb_io2 into raw[bit], only when bit < MATRIX_BITS.
  - Sampling happens in the same cycle the register toggles.
- Falling edge (kb_io0 going 1->0):
  - Increment bit, modulo FRAME_BITS.
  - Update kb_io1 for the new bit: 1 when bit==0 (sync); capslock_led when bit==1; 0 otherwise.
  - capslock_led is sampled at that falling edge.
- State machine:
  - SHIFT -> COMMIT on the falling edge where bit wraps FRAME_BITS-1 -> 0.
  - COMMIT lasts exactly one cycle, then returns to SHIFT; the clock divider keeps running throughout.
- COMMIT actions:
  - If raw == prev_raw, then matrix <= raw (two identical consecutive frames required).
  - prev_raw <= raw.
  - raw <= all 1s.
  - frame_done=1 for this single cycle, regardless of the compare result.
- After reset, the first frame can never update matrix (prev_raw=1s), unless no keys are pressed.
- matrix changes only in the COMMIT cycle, atomically; never mid-frame.
- Bits MATRIX_BITS..FRAME_BITS-1 are clocked but ignored.
- All outputs are registered; there is no combinational path from kb_io2 to any output.

Test Plan:
- Reset held, then released:
  - kb_io0 first rises 14 cycles after release; period = 28 cycles.
  - kb_io1=1 for the first kb period (bit 0).
  - matrix=72'hFF..FF.
- kb_io2 held at 1, capslock_led=1:
  - kb_io1 high in bit 0 and bit 1, 0 in bits 2..127.
  - frame_done pulses every 128*28=3584 cycles.
  - matrix stays all 1s.
- Keyboard model drives 0 at bit 5 in two consecutive frames:
  - matrix[5]=0 after the second frame_done only.
  - Every other matrix bit stays 1.
- Bit 5 low in one frame only, surrounded by frames with it high:
  - matrix[5] stays 1 (debounce).
- kb_io2 low only at bits 72..127:
  - matrix remains all 1s.
- reset_n pulsed low at bit 40 of a frame whose previous frame matched:
  - All outputs return to their reset values immediately.
  - No frame_done occurs for the aborted frame.
